// File: rtl/fma_result_drain.sv
// fma_result_drain: tracks live FMA pipeline slots, captures each result as it
// emerges, converts it to IEEE-754 binary32 and buffers it in a credit-managed
// FIFO behind a valid/ready handshake. The FMA cannot stall, so upstream issues
// are gated by credits that account for every result still in flight.
module fma_result_drain #(
  parameter int unsigned FMA_LATENCY  = 5,
  parameter int unsigned DEPTH        = 8,
  parameter int          EXP_BIAS_ADJ = 0,
  parameter int unsigned EXP_W        = 8,
  parameter int unsigned MANT_W       = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  // accNormalSigned_t packed as {exponent, signed mantissa}
  input  logic [EXP_W+MANT_W-1:0]   fma_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_data,
  output logic                      err_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FMA_LATENCY-1:0] track;
  logic [FMA_LATENCY-1:0] accept_vec;
  logic                   accept;
  logic                   conv_valid;
  logic [31:0]            conv_data;
  logic [31:0]            conv_word;
  logic [31:0]            mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   push;
  logic                   pop;
  logic                   full;

  assign accept    = issue_valid & issue_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = conv_valid & (~full | pop);

  // Accepted issue as a one-hot seed for the tracker shift register
  always_comb begin
    accept_vec    = '0;
    accept_vec[0] = accept;
  end

  // Tracker: each set bit marks a pipeline slot that holds a live result
  always_ff @(posedge clk) begin
    if (rst) track <= '0;
    else     track <= (track << 1) | accept_vec;
  end

  // Binary32 conversion of the word currently on the FMA output bus
  always_comb begin
    logic                  sign;
    logic [EXP_W-1:0]      exp_in;
    logic [MANT_W-1:0]     mant;
    logic [MANT_W-1:0]     mag;
    logic [MANT_W+22:0]    ext;
    logic [22:0]           frac;
    int                    biased;
    exp_in    = fma_out[EXP_W+MANT_W-1:MANT_W];
    mant      = fma_out[MANT_W-1:0];
    sign      = mant[MANT_W-1];
    mag       = sign ? (~mant + 1'b1) : mant;
    // Leading one sits at MANT_W-2; padding with zeros below covers narrow mantissas
    ext       = {mag, 23'b0};
    frac      = 23'(ext >> (MANT_W - 2));
    biased    = int'(exp_in) + EXP_BIAS_ADJ;
    conv_word = '0;
    if (mant == '0)
      conv_word = '0;
    else if (exp_in == '1 || biased >= 255)
      conv_word = {sign, 8'hFF, 23'b0};
    else if (biased <= 0)
      conv_word = {sign, 31'b0};
    else
      conv_word = {sign, 8'(biased), frac};
  end

  // Conversion stage: capture exactly when the tracked slot reaches the output
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_valid <= 1'b0;
      conv_data  <= '0;
    end else begin
      conv_valid <= track[FMA_LATENCY-1];
      if (track[FMA_LATENCY-1]) conv_data <= conv_word;
    end
  end

  // Result FIFO with wrap-around pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= conv_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credits: buffered plus in-flight results must leave room for one more
  always_comb begin
    int unsigned used;
    used = 32'(count) + 32'(conv_valid);
    for (int unsigned i = 0; i < FMA_LATENCY; i++) used = used + 32'(track[i]);
    issue_ready = (used < DEPTH);
  end

  // Sticky protocol-error flag for issues presented without a credit
  always_ff @(posedge clk) begin
    if (rst)                             err_overrun <= 1'b0;
    else if (issue_valid && !issue_ready) err_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_fma_result_drain.sv
// Self-checking bench for fma_result_drain: a driver replays operand words on
// fma_out FMA_LATENCY cycles after issue; expected binary32 words are queued at
// issue time and compared in order as the DUT hands them out.
module tb_fma_result_drain;

  localparam int FMA_LAT = 5;
  localparam int DEPTH   = 8;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [33:0] fma_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        err_overrun;

  typedef struct {
    int          due;
    logic [33:0] word;
  } drv_t;

  drv_t        dq[$];
  logic [31:0] sb[$];
  int          cyc    = 0;
  int          n_test = 0;
  int          n_fail = 0;
  int          n_out  = 0;

  fma_result_drain #(
    .FMA_LATENCY (FMA_LAT),
    .DEPTH       (DEPTH),
    .EXP_BIAS_ADJ(0),
    .EXP_W       (8),
    .MANT_W      (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .fma_out    (fma_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err_overrun(err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] conv_model(input logic [33:0] w);
    logic [7:0]  e;
    logic [25:0] m;
    logic [25:0] mag;
    logic        s;
    e   = w[33:26];
    m   = w[25:0];
    s   = m[25];
    mag = s ? -m : m;
    if (m == 26'd0)     return 32'h0;
    if (e == 8'hFF)     return {s, 8'hFF, 23'd0};
    if (e == 8'h00)     return {s, 31'd0};
    return {s, e, mag[23:1]};
  endfunction

  function automatic logic [33:0] rand_word();
    logic [25:0] m;
    logic [7:0]  e;
    m = 26'h1000000 | 26'($urandom_range(0, 24'hFFFFFF));
    if ($urandom_range(0, 1) == 1) m = -m;
    e = 8'($urandom_range(1, 254));
    return {e, m};
  endfunction

  // Replays each issued operand on fma_out in the cycle its result is due
  initial begin
    fma_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dq.size() > 0 && dq[0].due == cyc) begin
        fma_out = dq[0].word;
        void'(dq.pop_front());
      end else begin
        fma_out = 34'({$urandom(), $urandom()});
      end
    end
  end

  // Output monitor: every accepted word must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("unexpected_out", out_data, 32'hDEADBEEF);
        else                check("out_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_negedge_of(input int n);
    while (cyc < n) tick();
    @(negedge clk);
  endtask

  task automatic issue_exp(input logic [33:0] w, input logic [31:0] expv);
    drv_t d;
    d.due  = cyc + FMA_LAT;
    d.word = w;
    dq.push_back(d);
    sb.push_back(expv);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic issue(input logic [33:0] w);
    issue_exp(w, conv_model(w));
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    if (sb.size() > 0) check(tag, sb.size(), 0);
    repeat (4) tick();
  endtask

  task automatic fill_full(output int acc);
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      if (issue_ready) begin
        issue(rand_word());
        acc++;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ci;
    int acc;
    int out_before;
    logic [33:0] spec_w [5];
    logic [31:0] spec_e [5];

    rst = 1'b1;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);

    // Single op: +1.5 with exponent 127, visible exactly 7 cycles after issue
    out_ready = 1'b1;
    while (cyc < 10) tick();
    ci = cyc;
    issue_exp({8'd127, 26'h1800000}, 32'h3FC00000);
    at_negedge_of(ci + 6);
    check("single_early", 32'(out_valid), 32'd0);
    at_negedge_of(ci + 7);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'h3FC00000);
    at_negedge_of(ci + 8);
    check("single_late", 32'(out_valid), 32'd0);
    drain("single_drain");

    // Specials back-to-back: zero, -2.0, +Inf, -Inf, underflow
    spec_w[0] = {8'd127, 26'h0000000}; spec_e[0] = 32'h00000000;
    spec_w[1] = {8'd128, 26'h3000000}; spec_e[1] = 32'hC0000000;
    spec_w[2] = {8'd255, 26'h1000000}; spec_e[2] = 32'h7F800000;
    spec_w[3] = {8'd255, 26'h3000000}; spec_e[3] = 32'hFF800000;
    spec_w[4] = {8'd0,   26'h1000000}; spec_e[4] = 32'h00000000;
    ci = cyc;
    for (int k = 0; k < 5; k++) issue_exp(spec_w[k], spec_e[k]);
    for (int k = 0; k < 5; k++) begin
      at_negedge_of(ci + 7 + k);
      check("special_consecutive", 32'(out_valid), 32'd1);
    end
    at_negedge_of(ci + 12);
    check("special_end", 32'(out_valid), 32'd0);
    drain("special_drain");

    // Backpressure: exactly DEPTH issues accepted while the consumer is stalled
    out_ready = 1'b0;
    fill_full(acc);
    check("bp_accepted", 32'(acc), 32'(DEPTH));
    check("bp_ready_low", 32'(issue_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    // First pop; credit comes back the following cycle
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", 32'(issue_ready), 32'd0);
    tick();
    check("bp_ready_after_pop", 32'(issue_ready), 32'd1);
    // Issue and pop in the same cycle
    issue(rand_word());
    check("bp_overrun_clear", 32'(err_overrun), 32'd0);
    drain("bp_drain");
    check("bp_overrun_after", 32'(err_overrun), 32'd0);
    check("bp_ready_idle", 32'(issue_ready), 32'd1);

    // Random traffic with a jittery consumer
    for (int k = 0; k < 60; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (issue_ready && $urandom_range(0, 1) == 1) issue(rand_word());
      else tick();
    end
    out_ready = 1'b1;
    drain("rand_drain");

    // Protocol error: issue without a credit must be dropped and flagged
    out_ready = 1'b0;
    fill_full(acc);
    check("ovr_accepted", 32'(acc), 32'(DEPTH));
    out_before = n_out;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    check("ovr_flag", 32'(err_overrun), 32'd1);
    tick();
    out_ready = 1'b1;
    drain("ovr_drain");
    repeat (10) tick();
    check("ovr_out_count", 32'(n_out - out_before), 32'(DEPTH));
    check("ovr_sticky", 32'(err_overrun), 32'd1);

    // Reset mid-flight: 2 buffered plus 3 in the pipeline are discarded
    out_ready = 1'b0;
    issue(rand_word());
    issue(rand_word());
    repeat (8) tick();
    issue(rand_word());
    issue(rand_word());
    issue(rand_word());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    dq.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
    check("mid_rst_err_overrun", 32'(err_overrun), 32'd0);
    out_before = n_out;
    out_ready = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_output", 32'(n_out - out_before), 32'd0);

    // Post-reset sanity op
    issue(rand_word());
    drain("post_rst_drain");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule

// File: doc/fma_result_drain.md
Name: fma_result_drain

Overview:
- Sits directly downstream of the FMA at the bottom of a systolic column.
- Tracks which FMA pipeline slots hold live results and captures each `out` word exactly when it emerges.
- Converts each captured `accNormalSigned_t` result to packed IEEE-754 binary32 and buffers it in a FIFO behind a valid/ready handshake.
- The FMA pipeline cannot stall, so the block issues credits upstream and guarantees the FIFO never overflows.

Parameters:
- FMA_LATENCY, 5: cycles from operands presented to FMA until `out` carries the corresponding result.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- EXP_BIAS_ADJ, 0: signed constant added to `exponent_t` to form the binary32 biased exponent.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  FMA operands are presented this cycle and their result must be drained.
- issue_ready  out  1  a credit is available; issue_valid asserted while low is a protocol error.
- fma_out  in  $bits(accNormalSigned_t)  FMA `out` bus.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32  binary32 result.
- err_overrun  out  1  sticky; set when issue_valid is seen while issue_ready is low.

Behaviour:
- Reset values: out_valid=0, out_data=0, issue_ready=1, err_overrun=0. Reset also clears the valid shift register, the conversion stage, the FIFO pointers and the credit counter.
- Reset asserted mid-operation discards all in-flight and buffered results with no output.
- Tracker:
  - FMA_LATENCY-bit shift register; bit 0 loads (issue_valid & issue_ready) each cycle.
  - When the top bit is 1, fma_out is registered into the conversion stage on that edge.
  - An issue in cycle t captures fma_out in cycle t+FMA_LATENCY.
- Conversion (registered, 1 cycle):
  - sign = Mant MSB; magnitude = |Mant| in two's complement.
  - Leading one of a normalized magnitude is at bit width-2. Fraction = next 23 bits below it, truncated (round toward zero), zero-padded if fewer bits exist.
  - Exponent field = Exp + EXP_BIAS_ADJ.
  - Special cases:
    - Mant==0 gives +0 (0x00000000).
    - Exp all-ones gives ±Inf (0x7F800000 | sign<<31).
    - Biased exponent ≥255 gives ±Inf.
    - Biased exponent ≤0 gives ±0 (flush to zero).
- FIFO:
  - The conversion-stage result is written in the cycle after capture, i.e. available at out_data in cycle t+FMA_LATENCY+2 when the FIFO is empty.
  - out_data/out_valid come from the FIFO head register. Pop when out_valid & out_ready.
  - Simultaneous push and pop at full or empty is legal. Count is unchanged, except at empty, where the pushed word appears next cycle.
  - Pointers wrap modulo DEPTH.
  - out_data holds its value while out_valid & !out_ready.
- Credits:
  - inflight = popcount(shift register) + conversion-stage valid.
  - issue_ready = (fifo_count + inflight) < DEPTH, computed from registered state.
  - An accepted issue consumes a credit the same cycle; a pop returns it the next cycle.
  - Issue and pop in the same cycle net to zero.
- Overrun: issue_valid & !issue_ready sets err_overrun and the issue is ignored (no tracker bit). Only rst clears it.
- Ordering: results leave strictly in issue order; no drops, no duplication.

Test Plan:
- Single op: rst 2 cycles, issue at t=10 with fma_out at t=15 = {Exp=127-adjusted, Mant=+1.5 normalized}, out_ready=1 → out_valid high only in cycle 17, out_data=0x3FC00000.
- Specials: zero, negative 2.0, Exp all-ones, and underflowing exponent issued back-to-back → outputs 0x00000000, 0xC0000000, 0x7F800000/0xFF800000 by sign, 0x00000000 in order on consecutive cycles.
- Backpressure: out_ready=0, issue every cycle → exactly DEPTH=8 issues accepted and issue_ready low from then. Raise out_ready → 8 results drain in order and issue_ready returns 1 cycle after the first pop.
- Full with simultaneous events: FIFO full, one pop and one issue in the same cycle → count stays 8, no loss, err_overrun stays 0.
- Protocol error: force issue_valid while issue_ready=0 → err_overrun=1 permanently, no extra output word.
- Reset mid-flight: 3 issues in flight plus 2 buffered, assert rst → out_valid=0 next cycle, nothing emitted after deassertion, issue_ready=1.
